// File: rtl/bsg_dmc_ui_master.sv
// UI-side master for a DDR memory controller application port.
// It accepts one client request at a time, streams write beats to the
// controller's write-data FIFO and then issues the write command. For a read
// it issues the command and collects the returned burst into a small local
// FIFO that the client drains. Protocol violations raise a sticky error.
module bsg_dmc_ui_master #(
    parameter int ui_addr_width_p = 28,
    parameter int ui_data_width_p = 128,
    parameter int burst_len_p     = 2
) (
    input  logic                         ui_clk_i,
    input  logic                         ui_clk_sync_rst_n_i,
    input  logic                         init_calib_complete_i,

    input  logic                         req_v_i,
    input  logic                         req_write_i,
    input  logic [ui_addr_width_p-1:0]   req_addr_i,
    output logic                         req_ready_o,

    input  logic                         wdata_v_i,
    input  logic [ui_data_width_p-1:0]   wdata_i,
    input  logic [ui_data_width_p/8-1:0] wmask_i,
    output logic                         wdata_ready_o,

    output logic                         rdata_v_o,
    output logic [ui_data_width_p-1:0]   rdata_o,
    output logic                         rdata_last_o,
    input  logic                         rdata_yumi_i,

    output logic [ui_addr_width_p-1:0]   app_addr_o,
    output logic [2:0]                   app_cmd_o,
    output logic                         app_en_o,
    input  logic                         app_rdy_i,

    output logic                         app_wdf_wren_o,
    output logic                         app_wdf_end_o,
    output logic [ui_data_width_p-1:0]   app_wdf_data_o,
    output logic [ui_data_width_p/8-1:0] app_wdf_mask_o,
    input  logic                         app_wdf_rdy_i,

    input  logic                         app_rd_data_valid_i,
    input  logic                         app_rd_data_end_i,
    input  logic [ui_data_width_p-1:0]   app_rd_data_i,

    output logic                         error_o
);

    localparam int mask_width_lp = ui_data_width_p / 8;
    localparam int cnt_width_lp  = (burst_len_p > 1) ? $clog2(burst_len_p) : 1;
    localparam logic [cnt_width_lp-1:0] last_beat_lp = cnt_width_lp'(burst_len_p - 1);
    localparam logic [cnt_width_lp:0]   depth_lp     = (cnt_width_lp + 1)'(burst_len_p);
    localparam logic [cnt_width_lp-1:0] cnt_zero_lp  = {cnt_width_lp{1'b0}};
    localparam logic [cnt_width_lp-1:0] cnt_one_lp   = cnt_width_lp'(1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WDATA = 3'd1,
        WCMD  = 3'd2,
        RCMD  = 3'd3,
        RWAIT = 3'd4
    } state_e;

    localparam logic [2:0] cmd_write_lp = 3'b000;
    localparam logic [2:0] cmd_read_lp  = 3'b001;

    state_e                        state_r;
    state_e                        state_next_s;
    logic                          req_hs_s;
    logic                          wbeat_hs_s;
    logic [cnt_width_lp-1:0]       wr_cnt_r;
    logic [cnt_width_lp-1:0]       rd_cnt_r;
    logic [ui_addr_width_p-1:0]    app_addr_r;
    logic                          error_r;

    logic [ui_data_width_p-1:0]    fifo_mem_r [burst_len_p];
    logic [cnt_width_lp-1:0]       fifo_wr_ptr_r;
    logic [cnt_width_lp-1:0]       fifo_rd_ptr_r;
    logic [cnt_width_lp:0]         fifo_count_r;
    logic                          fifo_empty_s;
    logic                          fifo_full_s;
    logic                          push_s;
    logic                          pop_s;
    logic                          rbeat_s;
    logic                          drop_s;
    logic                          end_err_s;

    // Wrap a beat index / FIFO pointer back to zero after the last burst slot.
    function automatic logic [cnt_width_lp-1:0] beat_inc(input logic [cnt_width_lp-1:0] idx);
        return (idx == last_beat_lp) ? cnt_zero_lp : (idx + cnt_one_lp);
    endfunction

    assign fifo_empty_s = (fifo_count_r == (cnt_width_lp + 1)'(0));
    assign fifo_full_s  = (fifo_count_r == depth_lp);
    assign pop_s        = rdata_yumi_i & ~fifo_empty_s;
    assign rbeat_s      = app_rd_data_valid_i & (state_r == RWAIT);
    // A full FIFO can still take a beat when the same cycle frees a slot.
    assign push_s       = rbeat_s & (~fifo_full_s | pop_s);
    assign drop_s       = app_rd_data_valid_i & ~push_s;
    assign end_err_s    = rbeat_s & (app_rd_data_end_i != (rd_cnt_r == last_beat_lp));

    assign app_addr_o   = app_addr_r;
    assign error_o      = error_r;
    assign rdata_v_o    = ~fifo_empty_s;
    assign rdata_o      = fifo_empty_s ? {ui_data_width_p{1'b0}} : fifo_mem_r[fifo_rd_ptr_r];
    assign rdata_last_o = ~fifo_empty_s & (fifo_rd_ptr_r == last_beat_lp);

    // State register.
    always_ff @(posedge ui_clk_i) begin
        if (!ui_clk_sync_rst_n_i) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state and per-state handshake outputs.
    always_comb begin
        state_next_s   = state_r;
        req_ready_o    = 1'b0;
        wdata_ready_o  = 1'b0;
        app_wdf_wren_o = 1'b0;
        app_wdf_end_o  = 1'b0;
        app_wdf_data_o = {ui_data_width_p{1'b0}};
        app_wdf_mask_o = {mask_width_lp{1'b0}};
        app_en_o       = 1'b0;
        app_cmd_o      = cmd_write_lp;
        req_hs_s       = 1'b0;
        wbeat_hs_s     = 1'b0;
        case (state_r)
            IDLE: begin
                // Only start when the previous read burst has fully drained.
                req_ready_o = ui_clk_sync_rst_n_i & init_calib_complete_i & fifo_empty_s;
                req_hs_s    = req_v_i & req_ready_o;
                if (req_hs_s) begin
                    state_next_s = req_write_i ? WDATA : RCMD;
                end else begin
                    state_next_s = IDLE;
                end
            end
            WDATA: begin
                app_wdf_wren_o = wdata_v_i;
                wdata_ready_o  = app_wdf_rdy_i;
                app_wdf_data_o = wdata_i;
                app_wdf_mask_o = wmask_i;
                app_wdf_end_o  = wdata_v_i & (wr_cnt_r == last_beat_lp);
                wbeat_hs_s     = wdata_v_i & app_wdf_rdy_i;
                if (wbeat_hs_s && (wr_cnt_r == last_beat_lp)) begin
                    state_next_s = WCMD;
                end else begin
                    state_next_s = WDATA;
                end
            end
            WCMD: begin
                app_en_o  = 1'b1;
                app_cmd_o = cmd_write_lp;
                if (app_rdy_i) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = WCMD;
                end
            end
            RCMD: begin
                app_en_o  = 1'b1;
                app_cmd_o = cmd_read_lp;
                if (app_rdy_i) begin
                    state_next_s = RWAIT;
                end else begin
                    state_next_s = RCMD;
                end
            end
            RWAIT: begin
                if (rbeat_s && (rd_cnt_r == last_beat_lp)) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = RWAIT;
                end
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // Command address capture on request acceptance.
    always_ff @(posedge ui_clk_i) begin
        if (!ui_clk_sync_rst_n_i) begin
            app_addr_r <= {ui_addr_width_p{1'b0}};
        end else if (req_hs_s) begin
            app_addr_r <= req_addr_i;
        end
    end

    // Beat counters for the outgoing write burst and the incoming read burst.
    always_ff @(posedge ui_clk_i) begin
        if (!ui_clk_sync_rst_n_i) begin
            wr_cnt_r <= cnt_zero_lp;
            rd_cnt_r <= cnt_zero_lp;
        end else begin
            if (wbeat_hs_s) begin
                wr_cnt_r <= beat_inc(wr_cnt_r);
            end
            if (rbeat_s) begin
                rd_cnt_r <= beat_inc(rd_cnt_r);
            end
        end
    end

    // Read FIFO storage; entries are only observed when the FIFO is non-empty.
    always_ff @(posedge ui_clk_i) begin
        if (push_s) begin
            fifo_mem_r[fifo_wr_ptr_r] <= app_rd_data_i;
        end
    end

    // Read FIFO pointers and occupancy.
    always_ff @(posedge ui_clk_i) begin
        if (!ui_clk_sync_rst_n_i) begin
            fifo_wr_ptr_r <= cnt_zero_lp;
            fifo_rd_ptr_r <= cnt_zero_lp;
            fifo_count_r  <= (cnt_width_lp + 1)'(0);
        end else begin
            if (push_s) begin
                fifo_wr_ptr_r <= beat_inc(fifo_wr_ptr_r);
            end
            if (pop_s) begin
                fifo_rd_ptr_r <= beat_inc(fifo_rd_ptr_r);
            end
            case ({push_s, pop_s})
                2'b10:   fifo_count_r <= fifo_count_r + (cnt_width_lp + 1)'(1);
                2'b01:   fifo_count_r <= fifo_count_r - (cnt_width_lp + 1)'(1);
                default: fifo_count_r <= fifo_count_r;
            endcase
        end
    end

    // Sticky protocol error: stray or dropped read beats, misplaced burst end.
    always_ff @(posedge ui_clk_i) begin
        if (!ui_clk_sync_rst_n_i) begin
            error_r <= 1'b0;
        end else if (drop_s || end_err_s) begin
            error_r <= 1'b1;
        end
    end

endmodule

// File: tb/tb_bsg_dmc_ui_master.sv
module tb_bsg_dmc_ui_master;

    localparam logic [127:0] Z  = 128'h0;
    localparam logic [127:0] DA = {4{32'hAAAA_0001}};
    localparam logic [127:0] DB = {4{32'hBBBB_0002}};
    localparam logic [127:0] DC = {4{32'hCCCC_0003}};
    localparam logic [127:0] DD = {4{32'hDDDD_0004}};

    logic          clk = 1'b0;
    logic          rst_n;
    logic          calib;
    logic          req_v, req_write, req_ready;
    logic [27:0]   req_addr;
    logic          wdata_v, wdata_ready;
    logic [127:0]  wdata;
    logic [15:0]   wmask;
    logic          rdata_v, rdata_last, rdata_yumi;
    logic [127:0]  rdata;
    logic [27:0]   app_addr;
    logic [2:0]    app_cmd;
    logic          app_en, app_rdy;
    logic          wdf_wren, wdf_end, wdf_rdy;
    logic [127:0]  wdf_data;
    logic [15:0]   wdf_mask;
    logic          rd_valid, rd_end;
    logic [127:0]  rd_data;
    logic          error;

    int pass_cnt = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    bsg_dmc_ui_master dut (
        .ui_clk_i              (clk),
        .ui_clk_sync_rst_n_i   (rst_n),
        .init_calib_complete_i (calib),
        .req_v_i               (req_v),
        .req_write_i           (req_write),
        .req_addr_i            (req_addr),
        .req_ready_o           (req_ready),
        .wdata_v_i             (wdata_v),
        .wdata_i               (wdata),
        .wmask_i               (wmask),
        .wdata_ready_o         (wdata_ready),
        .rdata_v_o             (rdata_v),
        .rdata_o               (rdata),
        .rdata_last_o          (rdata_last),
        .rdata_yumi_i          (rdata_yumi),
        .app_addr_o            (app_addr),
        .app_cmd_o             (app_cmd),
        .app_en_o              (app_en),
        .app_rdy_i             (app_rdy),
        .app_wdf_wren_o        (wdf_wren),
        .app_wdf_end_o         (wdf_end),
        .app_wdf_data_o        (wdf_data),
        .app_wdf_mask_o        (wdf_mask),
        .app_wdf_rdy_i         (wdf_rdy),
        .app_rd_data_valid_i   (rd_valid),
        .app_rd_data_end_i     (rd_end),
        .app_rd_data_i         (rd_data),
        .error_o               (error)
    );

    typedef struct packed {
        logic         calib, req_v, req_w;
        logic [27:0]  addr;
        logic         wv;
        logic [127:0] wd;
        logic [15:0]  wm;
        logic         wrdy, ardy, rv, rend;
        logic [127:0] rd;
        logic         yumi;
        logic         e_rr, e_wr, e_wren, e_wend, e_en;
        logic [2:0]   e_cmd;
        logic [27:0]  e_addr;
        logic [127:0] e_wd;
        logic [15:0]  e_wm;
        logic         e_rv;
        logic [127:0] e_rd;
        logic         e_rl, e_err;
    } vec_t;

    vec_t vecs [20];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total_cnt++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end else begin
            pass_cnt++;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        req_v = 1'b0; req_write = 1'b0; req_addr = 28'h0;
        wdata_v = 1'b0; wdata = Z; wmask = 16'h0; wdf_rdy = 1'b0;
        app_rdy = 1'b0; rd_valid = 1'b0; rd_end = 1'b0; rd_data = Z;
        rdata_yumi = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        calib = 1'b0;
        clear_inputs();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_req_ready", req_ready, 1'b0);
        chk("rst_app_en", app_en, 1'b0);
        chk("rst_app_addr", app_addr, 28'h0);
        chk("rst_app_cmd", app_cmd, 3'b000);
        chk("rst_wren", wdf_wren, 1'b0);
        chk("rst_rdata_v", rdata_v, 1'b0);
        chk("rst_error", error, 1'b0);
        rst_n = 1'b1;
    endtask

    initial begin
        // in: calib reqv reqw addr wv wd wm wrdy ardy rv rend rd yumi
        // exp: req_ready wready wren wend en cmd addr wdf_data wdf_mask rdata_v rdata rlast err
        vecs[0]  = '{1'b1,1'b1,1'b1,28'h100, 1'b0,Z,16'h0, 1'b0,1'b0,1'b0,1'b0,Z,1'b0,
                     1'b1,1'b0,1'b0,1'b0,1'b0,3'b000,28'h0,  Z,16'h0, 1'b0,Z,1'b0,1'b0};
        vecs[1]  = '{1'b1,1'b0,1'b0,28'h0,   1'b1,DA,16'h0001, 1'b0,1'b0,1'b0,1'b0,Z,1'b0,
                     1'b0,1'b0,1'b1,1'b0,1'b0,3'b000,28'h100,DA,16'h0001, 1'b0,Z,1'b0,1'b0};
        vecs[2]  = vecs[1];
        vecs[3]  = vecs[1];
        vecs[4]  = '{1'b1,1'b0,1'b0,28'h0,   1'b1,DA,16'h0001, 1'b1,1'b0,1'b0,1'b0,Z,1'b0,
                     1'b0,1'b1,1'b1,1'b0,1'b0,3'b000,28'h100,DA,16'h0001, 1'b0,Z,1'b0,1'b0};
        vecs[5]  = '{1'b1,1'b0,1'b0,28'h0,   1'b1,DB,16'h8000, 1'b1,1'b0,1'b0,1'b0,Z,1'b0,
                     1'b0,1'b1,1'b1,1'b1,1'b0,3'b000,28'h100,DB,16'h8000, 1'b0,Z,1'b0,1'b0};
        vecs[6]  = '{1'b1,1'b0,1'b0,28'h0,   1'b0,Z,16'h0, 1'b0,1'b0,1'b0,1'b0,Z,1'b0,
                     1'b0,1'b0,1'b0,1'b0,1'b1,3'b000,28'h100,Z,16'h0, 1'b0,Z,1'b0,1'b0};
        vecs[7]  = vecs[6];
        vecs[8]  = '{1'b1,1'b0,1'b0,28'h0,   1'b0,Z,16'h0, 1'b0,1'b1,1'b0,1'b0,Z,1'b0,
                     1'b0,1'b0,1'b0,1'b0,1'b1,3'b000,28'h100,Z,16'h0, 1'b0,Z,1'b0,1'b0};
        vecs[9]  = '{1'b1,1'b0,1'b0,28'h0,   1'b0,Z,16'h0, 1'b0,1'b0,1'b0,1'b0,Z,1'b0,
                     1'b1,1'b0,1'b0,1'b0,1'b0,3'b000,28'h100,Z,16'h0, 1'b0,Z,1'b0,1'b0};
        vecs[10] = '{1'b1,1'b1,1'b0,28'h200, 1'b0,Z,16'h0, 1'b0,1'b0,1'b0,1'b0,Z,1'b0,
                     1'b1,1'b0,1'b0,1'b0,1'b0,3'b000,28'h100,Z,16'h0, 1'b0,Z,1'b0,1'b0};
        vecs[11] = '{1'b1,1'b0,1'b0,28'h0,   1'b0,Z,16'h0, 1'b0,1'b0,1'b0,1'b0,Z,1'b0,
                     1'b0,1'b0,1'b0,1'b0,1'b1,3'b001,28'h200,Z,16'h0, 1'b0,Z,1'b0,1'b0};
        vecs[12] = '{1'b1,1'b0,1'b0,28'h0,   1'b0,Z,16'h0, 1'b0,1'b1,1'b0,1'b0,Z,1'b0,
                     1'b0,1'b0,1'b0,1'b0,1'b1,3'b001,28'h200,Z,16'h0, 1'b0,Z,1'b0,1'b0};
        vecs[13] = '{1'b1,1'b0,1'b0,28'h0,   1'b0,Z,16'h0, 1'b0,1'b0,1'b0,1'b0,Z,1'b0,
                     1'b0,1'b0,1'b0,1'b0,1'b0,3'b000,28'h200,Z,16'h0, 1'b0,Z,1'b0,1'b0};
        vecs[14] = '{1'b1,1'b0,1'b0,28'h0,   1'b0,Z,16'h0, 1'b0,1'b0,1'b1,1'b0,DC,1'b0,
                     1'b0,1'b0,1'b0,1'b0,1'b0,3'b000,28'h200,Z,16'h0, 1'b0,Z,1'b0,1'b0};
        vecs[15] = '{1'b1,1'b0,1'b0,28'h0,   1'b0,Z,16'h0, 1'b0,1'b0,1'b1,1'b1,DD,1'b0,
                     1'b0,1'b0,1'b0,1'b0,1'b0,3'b000,28'h200,Z,16'h0, 1'b1,DC,1'b0,1'b0};
        vecs[16] = '{1'b1,1'b1,1'b1,28'h300, 1'b0,Z,16'h0, 1'b0,1'b0,1'b0,1'b0,Z,1'b0,
                     1'b0,1'b0,1'b0,1'b0,1'b0,3'b000,28'h200,Z,16'h0, 1'b1,DC,1'b0,1'b0};
        vecs[17] = '{1'b1,1'b1,1'b1,28'h300, 1'b0,Z,16'h0, 1'b0,1'b0,1'b0,1'b0,Z,1'b1,
                     1'b0,1'b0,1'b0,1'b0,1'b0,3'b000,28'h200,Z,16'h0, 1'b1,DC,1'b0,1'b0};
        vecs[18] = '{1'b1,1'b0,1'b0,28'h0,   1'b0,Z,16'h0, 1'b0,1'b0,1'b0,1'b0,Z,1'b1,
                     1'b0,1'b0,1'b0,1'b0,1'b0,3'b000,28'h200,Z,16'h0, 1'b1,DD,1'b1,1'b0};
        vecs[19] = '{1'b1,1'b0,1'b0,28'h0,   1'b0,Z,16'h0, 1'b0,1'b0,1'b0,1'b0,Z,1'b0,
                     1'b1,1'b0,1'b0,1'b0,1'b0,3'b000,28'h200,Z,16'h0, 1'b0,Z,1'b0,1'b0};

        do_reset();
        tick();

        // Controller not calibrated: requests must be ignored.
        calib = 1'b0; req_v = 1'b1; req_write = 1'b1; req_addr = 28'h0AB;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("nocal_req_ready", req_ready, 1'b0);
            chk("nocal_app_en", app_en, 1'b0);
            tick();
        end

        // Table: write burst with back-pressure, then read burst held in FIFO.
        for (int i = 0; i < 20; i++) begin
            calib = vecs[i].calib; req_v = vecs[i].req_v; req_write = vecs[i].req_w;
            req_addr = vecs[i].addr; wdata_v = vecs[i].wv; wdata = vecs[i].wd;
            wmask = vecs[i].wm; wdf_rdy = vecs[i].wrdy; app_rdy = vecs[i].ardy;
            rd_valid = vecs[i].rv; rd_end = vecs[i].rend; rd_data = vecs[i].rd;
            rdata_yumi = vecs[i].yumi;
            #1;
            chk($sformatf("v%0d_req_ready", i), req_ready, vecs[i].e_rr);
            chk($sformatf("v%0d_wdata_ready", i), wdata_ready, vecs[i].e_wr);
            chk($sformatf("v%0d_wren", i), wdf_wren, vecs[i].e_wren);
            chk($sformatf("v%0d_wend", i), wdf_end, vecs[i].e_wend);
            chk($sformatf("v%0d_app_en", i), app_en, vecs[i].e_en);
            chk($sformatf("v%0d_app_cmd", i), app_cmd, vecs[i].e_cmd);
            chk($sformatf("v%0d_app_addr", i), app_addr, vecs[i].e_addr);
            chk($sformatf("v%0d_wdf_data", i), wdf_data, vecs[i].e_wd);
            chk($sformatf("v%0d_wdf_mask", i), wdf_mask, vecs[i].e_wm);
            chk($sformatf("v%0d_rdata_v", i), rdata_v, vecs[i].e_rv);
            chk($sformatf("v%0d_rdata", i), rdata, vecs[i].e_rd);
            chk($sformatf("v%0d_rdata_last", i), rdata_last, vecs[i].e_rl);
            chk($sformatf("v%0d_error", i), error, vecs[i].e_err);
            tick();
        end

        // Simultaneous push and pop keeps occupancy at one entry.
        clear_inputs();
        req_v = 1'b1; req_addr = 28'h400; tick();
        req_v = 1'b0; app_rdy = 1'b1; tick();
        app_rdy = 1'b0; rd_valid = 1'b1; rd_data = DC; tick();
        rd_data = DD; rd_end = 1'b1; rdata_yumi = 1'b1;
        #1;
        chk("pp_first_rdata", rdata, DC);
        tick();
        clear_inputs();
        #1;
        chk("pp_rdata_v", rdata_v, 1'b1);
        chk("pp_rdata", rdata, DD);
        chk("pp_rdata_last", rdata_last, 1'b1);
        chk("pp_error", error, 1'b0);
        rdata_yumi = 1'b1; tick();
        rdata_yumi = 1'b0;
        #1;
        chk("pp_drained", rdata_v, 1'b0);
        chk("pp_req_ready", req_ready, 1'b1);

        // Burst end flagged on the wrong beat raises the error.
        req_v = 1'b1; req_addr = 28'h700; tick();
        req_v = 1'b0; app_rdy = 1'b1; tick();
        app_rdy = 1'b0; rd_valid = 1'b1; rd_end = 1'b1; rd_data = DA; tick();
        rd_valid = 1'b0; rd_end = 1'b0;
        #1;
        chk("endmis_error", error, 1'b1);

        // Stray read beat in IDLE: sticky error until reset.
        do_reset();
        calib = 1'b1; tick();
        rd_valid = 1'b1; rd_data = DA; tick();
        rd_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("stray_error", error, 1'b1);
            chk("stray_dropped", rdata_v, 1'b0);
            tick();
        end
        do_reset();

        // Reset in the middle of a write burst, then a clean write.
        calib = 1'b1; req_v = 1'b1; req_write = 1'b1; req_addr = 28'h500; tick();
        req_v = 1'b0; wdata_v = 1'b1; wdata = DA; wdf_rdy = 1'b1;
        #1;
        chk("abort_beat1_end", wdf_end, 1'b0);
        tick();
        rst_n = 1'b0; wdata = DB; tick();
        chk("abort_wren", wdf_wren, 1'b0);
        chk("abort_addr", app_addr, 28'h0);
        chk("abort_app_en", app_en, 1'b0);
        chk("abort_req_ready", req_ready, 1'b0);
        chk("abort_wdf_data", wdf_data, Z);
        rst_n = 1'b1; clear_inputs();
        #1;
        chk("post_rst_req_ready", req_ready, 1'b1);
        req_v = 1'b1; req_write = 1'b1; req_addr = 28'h600; tick();
        req_v = 1'b0; wdata_v = 1'b1; wdata = DC; wdf_rdy = 1'b1;
        #1;
        chk("new_w1_end", wdf_end, 1'b0);
        chk("new_w1_wren", wdf_wren, 1'b1);
        tick();
        wdata = DD;
        #1;
        chk("new_w2_end", wdf_end, 1'b1);
        chk("new_w2_data", wdf_data, DD);
        tick();
        wdata_v = 1'b0; wdf_rdy = 1'b0; app_rdy = 1'b1;
        #1;
        chk("new_cmd_en", app_en, 1'b1);
        chk("new_cmd_cmd", app_cmd, 3'b000);
        chk("new_cmd_addr", app_addr, 28'h600);
        chk("new_cmd_wren", wdf_wren, 1'b0);
        tick();
        app_rdy = 1'b0;
        #1;
        chk("new_done_en", app_en, 1'b0);
        chk("new_done_req_ready", req_ready, 1'b1);
        chk("new_done_error", error, 1'b0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
